pic_inta_sequencer: RTL and testbench

CPU-side interrupt acknowledge controller that sits downstream of the PIC. It watches the PIC's INT output and runs the two-pulse INTA bus cycle. It captures the interrupt vector the PIC drives on D during the second pulse and hands that vector to the CPU core through a valid/ack handshake. This is the only agent in the design that drives the PIC's INTA pin.

---
 rtl/pic_pkg.sv | 26 ++
 rtl/sync2.sv | 23 ++
 rtl/pic_inta_sequencer.sv | 144 ++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and default timing for the PIC interrupt-acknowledge sequencer.
package pic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_P1_LOW,
      ST_GAP,
      ST_P2_LOW,
      ST_HOLD,
      ST_RECOVER
   } inta_state_t;

   localparam int unsigned PULSE   = 2;
   localparam int unsigned GAP     = 2;
   localparam int unsigned RECOVER = 4;

   typedef logic [7:0] vec_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous PIC-side inputs; resets to zero.
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pic_inta_sequencer.sv
// CPU-side INTA controller: runs the two-pulse acknowledge cycle, captures the
// vector from the PIC and presents it to the core through a valid/ack handshake.
module pic_inta_sequencer
   import pic_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES   = PULSE,
   parameter int unsigned GAP_CYCLES     = GAP,
   parameter int unsigned RECOVER_CYCLES = RECOVER
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       INT,
   input  vec_t       D,
   output logic       INTA,
   input  logic       EN,
   output vec_t       VEC,
   output logic       VEC_VALID,
   input  logic       VEC_ACK,
   output logic       BUSY,
   output logic [7:0] ACK_COUNT
);

   localparam int unsigned CNT_MAX = max3(PULSE_CYCLES, GAP_CYCLES, RECOVER_CYCLES);
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t PULSE_LD   = cnt_t'(PULSE_CYCLES - 1);
   localparam cnt_t GAP_LD     = cnt_t'(GAP_CYCLES - 1);
   localparam cnt_t RECOVER_LD = cnt_t'(RECOVER_CYCLES - 1);

   inta_state_t state, state_d;
   cnt_t        cnt, cnt_d;
   logic        inta_q, inta_d;
   vec_t        vec_q, vec_d;
   logic        valid_q, valid_d;
   logic [7:0]  ack_cnt_q, ack_cnt_d;
   logic        int_s;
   logic        cnt_zero;

   sync2 #(.WIDTH(1)) u_int_sync (
      .CLK   (CLK),
      .RST_N (RST_N),
      .d     (INT),
      .q     (int_s)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         inta_q    <= 1'b1;
         vec_q     <= '0;
         valid_q   <= 1'b0;
         ack_cnt_q <= '0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         inta_q    <= inta_d;
         vec_q     <= vec_d;
         valid_q   <= valid_d;
         ack_cnt_q <= ack_cnt_d;
      end
   end

   assign cnt_zero = (cnt == '0);

   // One shared down-counter, reloaded with (duration-1) on every timed-state entry.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      inta_d    = inta_q;
      vec_d     = vec_q;
      valid_d   = valid_q;
      ack_cnt_d = ack_cnt_q;
      case (state)
         ST_IDLE: begin
            if (int_s && EN) begin
               state_d = ST_P1_LOW;
               cnt_d   = PULSE_LD;
               inta_d  = 1'b0;
            end
         end
         ST_P1_LOW: begin
            if (cnt_zero) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LD;
               inta_d  = 1'b1;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_zero) begin
               state_d = ST_P2_LOW;
               cnt_d   = PULSE_LD;
               inta_d  = 1'b0;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         ST_P2_LOW: begin
            if (cnt_zero) begin
               state_d   = ST_HOLD;
               cnt_d     = '0;
               inta_d    = 1'b1;
               vec_d     = D;
               valid_d   = 1'b1;
               ack_cnt_d = ack_cnt_q + 8'd1;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         ST_HOLD: begin
            if (VEC_ACK) begin
               state_d = ST_RECOVER;
               cnt_d   = RECOVER_LD;
               valid_d = 1'b0;
            end
         end
         ST_RECOVER: begin
            if (cnt_zero) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            inta_d  = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   assign INTA      = inta_q;
   assign VEC       = vec_q;
   assign VEC_VALID = valid_q;
   assign BUSY      = (state != ST_IDLE);
   assign ACK_COUNT = ack_cnt_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer with a PIC model feeding a vector scoreboard.
module tb_pic_inta_sequencer;

   localparam int unsigned P = 2;
   localparam int unsigned G = 2;
   localparam int unsigned R = 4;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       INT;
   logic [7:0] D;
   logic       INTA;
   logic       EN;
   logic [7:0] VEC;
   logic       VEC_VALID;
   logic       VEC_ACK;
   logic       BUSY;
   logic [7:0] ACK_COUNT;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned n_falls  = 0;
   int unsigned n_seq    = 0;
   int unsigned n_valid  = 0;
   int unsigned fall_cyc = 0;
   int unsigned rise_cyc = 0;
   int unsigned fall1_cyc = 0;
   int unsigned pulse_idx = 0;
   bit          aborted   = 1'b1;
   logic [7:0]  pic_vec;
   logic [7:0]  sb[$];

   pic_inta_sequencer #(
      .PULSE_CYCLES   (P),
      .GAP_CYCLES     (G),
      .RECOVER_CYCLES (R)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .INT       (INT),
      .D         (D),
      .INTA      (INTA),
      .EN        (EN),
      .VEC       (VEC),
      .VEC_VALID (VEC_VALID),
      .VEC_ACK   (VEC_ACK),
      .BUSY      (BUSY),
      .ACK_COUNT (ACK_COUNT)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // PIC model: drives the vector for the second pulse and records it as expected.
   always @(negedge INTA) begin
      n_falls++;
      if (pulse_idx == 1) begin
         if (!aborted) check("gap_width", cyc - rise_cyc, G);
         pulse_idx = 2;
         D = pic_vec;
         sb.push_back(pic_vec);
      end else begin
         pulse_idx = 1;
         fall1_cyc = cyc;
         n_seq++;
      end
      aborted  = 1'b0;
      fall_cyc = cyc;
   end

   always @(posedge INTA) begin
      if (!aborted) begin
         check("low_width", cyc - fall_cyc, P);
         rise_cyc = cyc;
         if (pulse_idx == 2) pulse_idx = 0;
      end
   end

   always @(negedge RST_N) begin
      aborted   = 1'b1;
      pulse_idx = 0;
      sb.delete();
   end

   always begin
      @(posedge VEC_VALID);
      n_valid++;
      #1;
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
      end else begin
         check("vec", VEC, sb.pop_front());
      end
      check("valid_latency", cyc - fall1_cyc, 2 * P + G);
   end

   task automatic wait_valid();
      int unsigned start = n_valid;
      for (int i = 0; i < 100 && n_valid == start; i++) begin
         @(posedge CLK);
         #1;
      end
      check("valid_timeout", 32'(n_valid != start), 32'd1);
   endtask

   task automatic wait_seq();
      int unsigned start = n_seq;
      for (int i = 0; i < 100 && n_seq == start; i++) begin
         @(posedge CLK);
         #1;
      end
      check("seq_timeout", 32'(n_seq != start), 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && BUSY; i++) begin
         @(posedge CLK);
         #1;
      end
      check("idle_timeout", BUSY, 32'd0);
   endtask

   task automatic ack();
      VEC_ACK = 1'b1;
      @(posedge CLK);
      #1;
      VEC_ACK = 1'b0;
   endtask

   initial begin
      int unsigned t0, a, prev, s, f;
      RST_N = 1'b0; INT = 1'b0; EN = 1'b0; VEC_ACK = 1'b0; D = '0; pic_vec = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_inta", INTA, 1);
      check("rst_valid", VEC_VALID, 0);
      check("rst_ack_count", ACK_COUNT, 0);
      check("rst_vec", VEC, 0);
      check("rst_busy", BUSY, 0);
      RST_N = 1'b1;
      repeat (20) @(posedge CLK);
      #1;
      check("idle_no_falls", n_falls, 0);
      check("idle_inta", INTA, 1);

      // First sequence
      pic_vec = 8'h31; EN = 1'b1; INT = 1'b1; t0 = cyc;
      wait_valid();
      check("int_to_fall", fall1_cyc - t0, 3);
      check("ack_count_1", ACK_COUNT, 1);
      check("two_pulses", n_falls, 2);

      // Withheld ack: vector held, no new pulse
      repeat (10) begin
         @(posedge CLK);
         #1;
         check("hold_valid", VEC_VALID, 1);
         check("hold_vec", VEC, 8'h31);
      end
      check("no_restart_in_hold", n_falls, 2);
      pic_vec = 8'h32;
      ack();
      check("ack_clears_valid", VEC_VALID, 0);
      check("vec_kept", VEC, 8'h31);
      a = cyc;
      wait_seq();
      check("recover_restart", fall1_cyc - a, R + 1);

      // Ack held high: single-cycle HOLD and minimum sequence period
      VEC_ACK = 1'b1;
      wait_valid();
      prev = fall1_cyc;
      pic_vec = 8'h33;
      @(posedge CLK);
      #1;
      check("hold_one_cycle", VEC_VALID, 0);
      wait_seq();
      check("min_period", fall1_cyc - prev, 2 * P + G + 1 + R + 1);
      INT = 1'b0;
      wait_valid();
      wait_idle();
      VEC_ACK = 1'b0;

      // EN gating
      EN = 1'b0; INT = 1'b1; pic_vec = 8'h41; s = n_seq;
      repeat (20) @(posedge CLK);
      #1;
      check("en_blocks_start", n_seq, s);
      check("en_blocks_busy", BUSY, 0);
      EN = 1'b1;
      wait_seq();
      repeat (2) @(posedge CLK);
      #1;
      check("busy_in_gap", BUSY, 1);
      check("inta_high_in_gap", INTA, 1);
      EN = 1'b0;
      wait_valid();
      check("en_drop_vec", VEC, 8'h41);
      ack();
      INT = 1'b0;
      wait_idle();
      EN = 1'b1;

      // INT dropped mid-sequence: default vector captured
      pic_vec = 8'h37; INT = 1'b1;
      wait_seq();
      INT = 1'b0;
      wait_valid();
      check("int_drop_vec", VEC, 8'h37);
      ack();
      wait_idle();

      // Reset during pulse 2
      pic_vec = 8'h55; INT = 1'b1;
      wait_seq();
      f = n_falls;
      for (int i = 0; i < 20 && n_falls == f; i++) begin
         @(posedge CLK);
         #1;
      end
      check("p2_reached", 32'(n_falls != f), 1);
      #2 RST_N = 1'b0;
      #1;
      check("rst_mid_inta", INTA, 1);
      check("rst_mid_valid", VEC_VALID, 0);
      check("rst_mid_busy", BUSY, 0);
      check("rst_mid_ack_count", ACK_COUNT, 0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1; VEC_ACK = 1'b1; pic_vec = 8'h56;
      wait_valid();
      check("fresh_ack_count", ACK_COUNT, 1);

      // Counter wrap after 256 sequences
      for (int i = 0; i < 255; i++) begin
         pic_vec = 8'(i);
         wait_valid();
         check("ack_count", ACK_COUNT, 32'((i + 2) % 256));
      end
      INT = 1'b0;
      wait_idle();
      VEC_ACK = 1'b0;
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
